// File: rtl/ec_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : ec_pkg
//  Description: Opcode, state and accumulator-source codes shared by the
//               accumulator-processor control unit.
//  Revision   : 1.0 - initial release
// ============================================================================
package ec_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [3:0] S_START  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_LOAD   = 4'd8;
    localparam logic [3:0] S_STORE  = 4'd9;
    localparam logic [3:0] S_ADD    = 4'd10;
    localparam logic [3:0] S_SUB    = 4'd11;
    localparam logic [3:0] S_INPUT  = 4'd12;
    localparam logic [3:0] S_JZ     = 4'd13;
    localparam logic [3:0] S_JPOS   = 4'd14;
    localparam logic [3:0] S_HALT   = 4'd15;

    localparam logic [1:0] ASEL_ALU = 2'b00;
    localparam logic [1:0] ASEL_IN  = 2'b01;
    localparam logic [1:0] ASEL_RAM = 2'b10;

endpackage
`default_nettype wire

// File: rtl/ec_controller_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module     : edge_detect
//  Description: Rising-edge detector for a level already synchronised to clk.
//  Revision   : 1.0 - initial release
// ============================================================================
module edge_detect (
    input  logic clk,
    input  logic clear,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic d_d;

    always_comb begin
        d_d = clear ? 1'b0 : d;
    end

    always_ff @(posedge clk) begin
        d_q <= d_d;
    end

    assign rise = d & ~d_q;

endmodule
`default_nettype wire

// File: rtl/ec_controller.sv
`default_nettype none
// ============================================================================
//  Module     : ec_controller
//  Description: Fetch/decode/execute sequencer and control-strobe decode for
//               the 8-bit accumulator processor, with Enter handshake and HALT.
//  Revision   : 1.0 - initial release
// ============================================================================
module ec_controller
    import ec_pkg::*;
#(
    parameter int OPW   = 3,
    parameter int ASELW = 2,
    parameter int STW   = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enter,
    input  logic [OPW-1:0]   IR75,
    input  logic             Aeq0,
    input  logic             Apos,
    output logic             IRload,
    output logic             JMPmux,
    output logic             PCload,
    output logic             Meminst,
    output logic             MemWr,
    output logic [ASELW-1:0] Asel,
    output logic             Aload,
    output logic             Sub,
    output logic             halt,
    output logic             inwait,
    output logic [STW-1:0]   state_out
);

    logic [STW-1:0] state_q;
    logic [STW-1:0] state_d;
    logic           enter_rise;

    edge_detect u_enter_edge (
        .clk   (clk),
        .clear (clear),
        .d     (enter),
        .rise  (enter_rise)
    );

    always_comb begin
        state_d = S_START;
        if (!clear) begin
            case (state_q)
                S_START:  state_d = S_FETCH;
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    case (IR75)
                        OP_LOAD:  state_d = S_LOAD;
                        OP_STORE: state_d = S_STORE;
                        OP_ADD:   state_d = S_ADD;
                        OP_SUB:   state_d = S_SUB;
                        OP_INPUT: state_d = S_INPUT;
                        OP_JZ:    state_d = S_JZ;
                        OP_JPOS:  state_d = S_JPOS;
                        default:  state_d = S_HALT;
                    endcase
                end
                S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: state_d = S_FETCH;
                S_INPUT:  state_d = enter_rise ? S_FETCH : S_INPUT;
                S_HALT:   state_d = S_HALT;
                default:  state_d = S_START;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) state_q <= S_START;
        else       state_q <= state_d;
    end

    // Strobes are held low for the whole clear cycle so reset can never write RAM.
    always_comb begin
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Asel    = ASEL_ALU;
        Aload   = 1'b0;
        Sub     = 1'b0;
        halt    = 1'b0;
        inwait  = 1'b0;
        if (!clear) begin
            case (state_q)
                S_FETCH: begin
                    IRload = 1'b1;
                    PCload = 1'b1;
                end
                S_DECODE: Meminst = 1'b1;
                S_LOAD: begin
                    Meminst = 1'b1;
                    Asel    = ASEL_RAM;
                    Aload   = 1'b1;
                end
                S_STORE: begin
                    Meminst = 1'b1;
                    MemWr   = 1'b1;
                end
                S_ADD: begin
                    Meminst = 1'b1;
                    Aload   = 1'b1;
                end
                S_SUB: begin
                    Meminst = 1'b1;
                    Aload   = 1'b1;
                    Sub     = 1'b1;
                end
                S_INPUT: begin
                    inwait = 1'b1;
                    Asel   = ASEL_IN;
                    Aload  = enter_rise;
                end
                S_JZ: begin
                    Meminst = 1'b1;
                    JMPmux  = 1'b1;
                    PCload  = Aeq0;
                end
                S_JPOS: begin
                    Meminst = 1'b1;
                    JMPmux  = 1'b1;
                    PCload  = Apos;
                end
                S_HALT:  halt = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_out = state_q;

endmodule
`default_nettype wire
